// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART program loader.
// UART_LOADER_CHECKSUM_EN adds the trailing checksum state.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BASE  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int bpw(input int data_w);
    return data_w / 8;
  endfunction

  // Wide enough to hold TIMEOUT_CYCLES itself; never zero bits.
  function automatic int tmo_w(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns a receiver valid (pulse or level) into one strobe per byte and
// flags an over-long gap between bytes while run is high.
module uart_byte_strobe
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_valid,
  input  logic run,
  output logic byte_stb,
  output logic timeout_stb
);

  localparam int TW = tmo_w(TIMEOUT_CYCLES);

  logic rx_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rx_valid_q <= 1'b0;
    else        rx_valid_q <= rx_valid;
  end

  assign byte_stb = rx_valid & ~rx_valid_q;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      logic [TW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (byte_stb || !run)
          cnt_d = '0;
        else if (cnt_q != TW'(TIMEOUT_CYCLES))
          cnt_d = cnt_q + TW'(1);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      // A byte landing on the expiry cycle takes priority over the timeout.
      assign timeout_stb = run & ~byte_stb & (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tmo
      assign timeout_stb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_loader.sv
// Parses SYNC/BASE/COUNT/DATA[/CSUM] frames from the UART and writes words
// to instruction memory. UART_LOADER_CHECKSUM_EN enables the CSUM byte.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          DATA_W         = 16,
  parameter int          ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT_CYCLES = 270000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BPW = bpw(DATA_W);
  localparam int BW  = idx_w(BPW);

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CSUM;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        widx_q, widx_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [DATA_W-1:0] word_q, word_d, word_shift;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              error_q, error_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d, csum_sum;
`endif

  logic byte_stb, timeout_stb, run;

  assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  uart_byte_strobe #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_strobe (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .run        (run),
    .byte_stb   (byte_stb),
    .timeout_stb(timeout_stb)
  );

  assign word_shift = (word_q << 8) | DATA_W'(rx_data);
`ifdef UART_LOADER_CHECKSUM_EN
  assign csum_sum = csum_q + rx_data;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_stb && (rx_data == SYNC_BYTE)) begin
          state_d = ST_BASE;
          error_d = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      ST_BASE: begin
        if (byte_stb) begin
          base_d  = ADDR_W'(rx_data);
          state_d = ST_COUNT;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d  = csum_sum;
`endif
        end
      end
      ST_COUNT: begin
        if (byte_stb) begin
          count_d = rx_data;
          widx_d  = 8'd0;
          bidx_d  = '0;
          word_d  = '0;
          state_d = (rx_data == 8'd0) ? ST_TAIL : ST_DATA;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d  = csum_sum;
`endif
        end
      end
      ST_DATA: begin
        if (byte_stb) begin
          word_d = word_shift;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_sum;
`endif
          if (bidx_q == BW'(BPW - 1)) begin
            // Address wraps naturally in ADDR_W bits.
            we_d    = 1'b1;
            addr_d  = base_q + ADDR_W'(widx_q);
            wdata_d = word_shift;
            bidx_d  = '0;
            widx_d  = widx_q + 8'd1;
            if (widx_q == count_q - 8'd1)
              state_d = ST_TAIL;
          end else begin
            bidx_d = bidx_q + BW'(1);
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_stb) begin
          csum_d = csum_sum;
          if (csum_sum == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Only fires in running states with no byte this cycle.
    if (timeout_stb) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= 8'd0;
      widx_q  <= 8'd0;
      bidx_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Downstream consumer of the UART receiver's byte stream (dataOut/valid).
- Parses framed program-load packets and writes the assembled words into CPU instruction memory through a simple write port.
- Holds the CPU in reset (busy) while a frame is in flight.
- Reports completion and error status.

Parameters:
- DATA_W, 16: memory word width; must be a multiple of 8. BPW = DATA_W/8 bytes per word.
- ADDR_W, 8: memory address width, ≥ 8.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 270000: maximum idle gap between bytes inside a frame (10 ms at 27 MHz). 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  byte-ready from the receiver; may be a pulse or a held level.
- mem_we  output  1  one-cycle write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- busy  output  1  high in any state other than IDLE; used as the CPU reset hold.
- done  output  1  one-cycle pulse when a frame completes successfully.
- error  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values (rst_n=0 at a clk edge): state=IDLE, all outputs 0, counters 0, checksum 0, timeout counter 0.
  - Reset mid-frame aborts the frame immediately. No further mem_we is issued.
- Byte accept: a byte is accepted on the rising edge of rx_valid (rx_valid & ~rx_valid_q). A level held for N cycles counts as one byte. rx_data is sampled in the accept cycle.
- Frame format: SYNC, BASE (8b, zero-extended to ADDR_W), COUNT (8b, number of words, 0..255), COUNT×BPW data bytes (MSB byte first), then CSUM (only when the checksum feature is enabled).
- FSM states: IDLE, BASE, COUNT, DATA, CSUM, DONE.
  - IDLE: non-SYNC bytes are ignored. On SYNC: clear error and the checksum, go to BASE.
  - BASE: latch the base address, add it to the checksum, go to COUNT.
  - COUNT: latch the word count, add it to the checksum. If COUNT=0, go to CSUM (or DONE when the checksum is disabled); otherwise go to DATA.
  - DATA: shift each byte into the word register, MSB first, and add it to the checksum.
    - On the BPW-th byte: mem_we=1 the next cycle, with mem_addr=base+word_idx (modulo 2^ADDR_W, wraps) and mem_wdata=the assembled word.
    - After the last word, go to CSUM or DONE.
  - CSUM: add the received byte to the checksum. If the 8-bit sum is 0, go to DONE; otherwise set error=1 and go to IDLE. done is not pulsed, and writes already issued are not rolled back.
  - DONE: done=1 for one cycle, then IDLE.
- Write latency: mem_we asserts exactly 1 cycle after the accept cycle of a word's final byte.
  - mem_addr/mem_wdata are valid only while mem_we=1 and hold their last value otherwise.
- Checksum: 8-bit modulo-256 sum of BASE, COUNT, all data bytes and CSUM; a valid frame sums to 0. SYNC is excluded.
- Timeout: the counter resets on every accepted byte and runs in every non-IDLE, non-DONE state.
  - When it reaches TIMEOUT_CYCLES: error=1, go to IDLE, partial word discarded.
  - If a byte is accepted in the same cycle the timeout would expire, the byte wins and the counter restarts.
- error: sticky; cleared only by reset or by acceptance of a new SYNC byte.
- A SYNC value inside BASE/COUNT/DATA/CSUM is treated as data, not as a resync.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined: the CSUM byte is expected and checked as above.
- Undefined: no CSUM state and no checksum register. After the last word (or COUNT=0) the FSM goes directly to DONE; error is raised only by timeout.

Decomposition:
- Shared header/package loader_pkg: state encodings, default SYNC_BYTE, the BPW derivation, and the timeout counter width via $clog2(TIMEOUT_CYCLES+1).
- One natural sub-module: uart_byte_strobe. It does rx_valid edge detection plus the inter-byte timeout counter, outputs byte_stb/timeout_stb, and is reused by future UART consumers.

Test Plan (checksum enabled, DATA_W=16, ADDR_W=8, TIMEOUT_CYCLES=1000 unless stated):
1. Send A5 10 02 12 34 AB CD 30 -> mem_we twice: (0x10, 0x1234) then (0x11, 0xABCD); done pulses once; error=0; busy low after DONE.
2. Send A5 FF 02 00 01 00 02 FC -> writes at 0xFF then 0x00 (address wraps); done=1.
3. Send A5 10 02 12 34 AB CD 31 -> both writes issued, error=1, no done. A following 55 is ignored; a following A5 clears error.
4. Send A5 10 then silence -> after 1000 cycles error=1, busy=0, no mem_we. Repeat with a byte arriving on the expiry cycle -> no error.
5. Send A5 20 00 E0 with rx_valid held high 5 cycles per byte -> each byte is counted once, no mem_we, done=1.
6. Assert rst_n=0 after the third data byte of test 1 -> first write already done, no second write, all outputs 0, state IDLE. Build without UART_LOADER_CHECKSUM_EN and send A5 10 01 BE EF -> write (0x10, 0xBEEF), done=1.
